decoder_sweep_capture: RTL and testbench

DECODER_SWEEP_CAPTURE -- requirements
Module: decoder_sweep_capture

---
 rtl/decoder_pkg.sv | 17 +
 rtl/settle_timer.sv | 38 +++
 rtl/decoder_sweep_capture.sv | 165 ++++++++++++++++
 tb/tb_decoder_sweep_capture.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder sweep/capture block.
//   state_e   : sweep controller states
//   NUM_CODES : number of input codes applied to the downstream decoder
//   CODE_W    : width of the code index {d1,c1,d,c}
package decoder_pkg;

    localparam int unsigned NUM_CODES = 16;
    localparam int unsigned CODE_W    = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DIS_STEP   = 2'd1,
        SWEEP_STEP = 2'd2,
        DONE       = 2'd3
    } state_e;

endpackage : decoder_pkg

// File: rtl/settle_timer.sv
// Settle timer: counts 0..SETTLE_CYCLES-1 for each step of the sweep.
//   clk, rst_n : clock, async active-low reset
//   load       : restart the step count at 0 on the next edge
//   last       : high on the final cycle of the current step
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic last
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last = (cnt_q == CNT_MAX);

    // Wrap at the end of a step so the counter never leaves 0..SETTLE_CYCLES-1.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (load || last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : settle_timer

// File: rtl/decoder_sweep_capture.sv
// Sweeps a 4-bit code plus enable into an external combinational decoder
// function and captures its response: once with en=0 (dis_val), then for
// codes 0..15 with en=1 (table_out).
//   clk, rst_n      : clock, async active-low reset
//   start, abort    : begin a sweep / cancel a sweep in progress
//   c, d, c1, d1    : code bits 0..3 to the decoder function
//   en              : enable to the decoder function
//   f               : decoder function result
//   table_out       : captured truth table, bit i = f for code i with en=1
//   dis_val         : f captured with en=0, code 0
//   busy, done      : sweep in progress / one-cycle completion pulse
module decoder_sweep_capture
    import decoder_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 c,
    output logic                 d,
    output logic                 c1,
    output logic                 d1,
    output logic                 en,
    input  logic                 f,
    output logic [NUM_CODES-1:0] table_out,
    output logic                 dis_val,
    output logic                 busy,
    output logic                 done
);

    localparam logic [CODE_W-1:0] LAST_IDX = CODE_W'(NUM_CODES - 1);

    state_e                state_q, state_d;
    logic [CODE_W-1:0]     idx_q, idx_d;
    logic [CODE_W-1:0]     code_q, code_d;
    logic                  en_q, en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [NUM_CODES-1:0]  table_q, table_d;
    logic                  dis_q, dis_d;

    logic                  last_c;
    logic                  load_c;

    // Step timer only runs while a step is being held; otherwise parked at 0.
    assign load_c = ((state_q != DIS_STEP) && (state_q != SWEEP_STEP)) || abort;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_c),
        .last  (last_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        code_d  = code_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        table_d = table_q;
        dis_d   = dis_q;

        unique case (state_q)
            IDLE: begin
                en_d   = 1'b0;
                code_d = '0;
                busy_d = 1'b0;
                // Abort wins over a simultaneous start.
                if (start && !abort) begin
                    state_d = DIS_STEP;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    table_d = '0;
                    dis_d   = 1'b0;
                end
            end

            DIS_STEP: begin
                if (abort) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    code_d  = '0;
                    busy_d  = 1'b0;
                end else if (last_c) begin
                    dis_d   = f;
                    en_d    = 1'b1;
                    idx_d   = '0;
                    code_d  = '0;
                    state_d = SWEEP_STEP;
                end
            end

            SWEEP_STEP: begin
                if (abort) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    code_d  = '0;
                    busy_d  = 1'b0;
                end else if (last_c) begin
                    table_d[idx_q] = f;
                    // Exit at the final code instead of letting idx wrap.
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        en_d    = 1'b0;
                        code_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + CODE_W'(1);
                        code_d = idx_q + CODE_W'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            code_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            dis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            table_q <= table_d;
            dis_q   <= dis_d;
        end
    end

    assign c         = code_q[0];
    assign d         = code_q[1];
    assign c1        = code_q[2];
    assign d1        = code_q[3];
    assign en        = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign dis_val   = dis_q;

endmodule : decoder_sweep_capture

// File: tb/tb_decoder_sweep_capture.sv
// Directed bench for decoder_sweep_capture: one instance with 4 settle
// cycles, one with 1, each driving a small behavioural decoder model.
module tb_decoder_sweep_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_r, abort_r;
    logic sel;      // 0: drive/observe 4-cycle instance, 1: 1-cycle instance
    logic f_mode;   // 0: f = en & (code==5 | code==10), 1: f = ~en

    // 4-cycle instance
    logic start4, abort4, c4, d4, c14, d14, en4, f4, dis4, busy4, done4;
    logic [15:0] table4;
    // 1-cycle instance
    logic start1, abort1, c1_1, d_1, c1b, d1_1, en1, f1, dis1, busy1, done1;
    logic [15:0] table1;

    assign start4 = start_r & ~sel;
    assign abort4 = abort_r & ~sel;
    assign start1 = start_r & sel;
    assign abort1 = abort_r & sel;

    logic [3:0] code4, code1;
    assign code4 = {d14, c14, d4, c4};
    assign code1 = {d1_1, c1b, d_1, c1_1};

    assign f4 = f_mode ? ~en4 : (en4 & ((code4 == 4'd5) || (code4 == 4'd10)));
    assign f1 = f_mode ? ~en1 : (en1 & ((code1 == 4'd5) || (code1 == 4'd10)));

    decoder_sweep_capture #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .c(c4), .d(d4), .c1(c14), .d1(d14), .en(en4), .f(f4),
        .table_out(table4), .dis_val(dis4), .busy(busy4), .done(done4)
    );

    decoder_sweep_capture #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .c(c1_1), .d(d_1), .c1(c1b), .d1(d1_1), .en(en1), .f(f1),
        .table_out(table1), .dis_val(dis1), .busy(busy1), .done(done1)
    );

    logic        m_busy, m_done, m_en, m_dis;
    logic [3:0]  m_code;
    logic [15:0] m_table;
    assign m_busy  = sel ? busy1  : busy4;
    assign m_done  = sel ? done1  : done4;
    assign m_en    = sel ? en1    : en4;
    assign m_dis   = sel ? dis1   : dis4;
    assign m_code  = sel ? code1  : code4;
    assign m_table = sel ? table1 : table4;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    bit         h_busy [256];
    bit         h_done [256];
    bit         h_en   [256];
    logic [3:0] h_code [256];

    // Pulse/hold start, then record n cycles; cycle 1 follows the edge that samples start.
    task automatic run(input int n, input int abort_at, input int hold);
        for (int i = 0; i < 256; i++) begin
            h_busy[i] = 1'b0; h_done[i] = 1'b0; h_en[i] = 1'b0; h_code[i] = 4'd0;
        end
        start_r = 1'b1;
        abort_r = 1'b0;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= n; cyc++) begin
            start_r = (cyc < hold);
            abort_r = (cyc == abort_at);
            h_busy[cyc] = m_busy;
            h_done[cyc] = m_done;
            h_en[cyc]   = m_en;
            h_code[cyc] = m_code;
            @(posedge clk); #1;
        end
        start_r = 1'b0;
        abort_r = 1'b0;
    endtask

    task automatic stats(input int n, output int busy_n, output int done_n,
                         output int done_at, output int en_at, output int en_n);
        busy_n = 0; done_n = 0; done_at = 0; en_at = 0; en_n = 0;
        for (int i = 1; i <= n; i++) begin
            if (h_busy[i]) busy_n++;
            if (h_en[i]) en_n++;
            if (h_done[i]) begin
                done_n++;
                if (done_at == 0) done_at = i;
            end
            if (h_en[i] && en_at == 0) en_at = i;
        end
    endtask

    int busy_n, done_n, done_at, en_at, en_n;

    initial begin
        rst_n   = 1'b0;
        start_r = 1'b0;
        abort_r = 1'b0;
        sel     = 1'b0;
        f_mode  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy4, done4, en4, code4, dis4, table4}, 32'h0);
        rst_n = 1'b1;

        // Basic sweep, started on the first edge after reset release.
        run(80, 0, 1);
        stats(80, busy_n, done_n, done_at, en_at, en_n);
        check("s4_busy_cycles", busy_n, 68);
        check("s4_done_count", done_n, 1);
        check("s4_done_cycle", done_at, 69);
        check("s4_first_en", en_at, 5);
        check("s4_code_c8", h_code[8], 0);
        check("s4_code_c9", h_code[9], 1);
        check("s4_code_c68", h_code[68], 15);
        check("s4_en_after", h_en[69], 0);
        check("s4_table", table4, 16'h0420);
        check("s4_dis", dis4, 0);

        // Inverted model: only the disabled sample reads 1.
        f_mode = 1'b1;
        run(80, 0, 1);
        check("inv_dis", dis4, 1);
        check("inv_table", table4, 16'h0000);
        f_mode = 1'b0;

        // Abort early in the sweep.
        run(100, 20, 1);
        stats(100, busy_n, done_n, done_at, en_at, en_n);
        check("ab20_busy_c20", h_busy[20], 1);
        check("ab20_busy_c21", h_busy[21], 0);
        check("ab20_done_count", done_n, 0);
        check("ab20_en_cycles", en_n, 16);
        check("ab20_code_c21", h_code[21], 0);
        check("ab20_table", table4, 16'h0000);

        // Abort after code 5 was captured: partial table retained.
        run(60, 40, 1);
        stats(60, busy_n, done_n, done_at, en_at, en_n);
        check("ab40_done_count", done_n, 0);
        check("ab40_table", table4, 16'h0020);

        // Simultaneous start and abort in IDLE: stays idle, table untouched.
        start_r = 1'b1;
        abort_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        abort_r = 1'b0;
        check("sa_busy", busy4, 0);
        check("sa_table", table4, 16'h0020);
        @(posedge clk); #1;
        check("sa_busy_next", busy4, 0);

        // Asynchronous reset mid-sweep, then a clean sweep.
        run(30, 0, 1);
        check("pre_rst_table", table4, 16'h0020);
        #2 rst_n = 1'b0;
        #1;
        check("rst_outputs", {busy4, done4, en4, code4, dis4, table4}, 32'h0);
        @(posedge clk); #1;
        check("rst_hold_done", done4, 0);
        rst_n = 1'b1;
        run(80, 0, 1);
        stats(80, busy_n, done_n, done_at, en_at, en_n);
        check("post_rst_done_cycle", done_at, 69);
        check("post_rst_done_count", done_n, 1);
        check("post_rst_table", table4, 16'h0420);

        // start held for 30 cycles: exactly one sweep.
        run(150, 0, 30);
        stats(150, busy_n, done_n, done_at, en_at, en_n);
        check("hold_done_count", done_n, 1);
        check("hold_done_cycle", done_at, 69);
        check("hold_busy_cycles", busy_n, 68);
        check("hold_table", table4, 16'h0420);

        // Single-cycle settle: code advances every cycle.
        sel = 1'b1;
        run(30, 0, 1);
        stats(30, busy_n, done_n, done_at, en_at, en_n);
        check("s1_done_cycle", done_at, 18);
        check("s1_done_count", done_n, 1);
        check("s1_busy_cycles", busy_n, 17);
        check("s1_first_en", en_at, 2);
        check("s1_code_c3", h_code[3], 1);
        check("s1_code_c17", h_code[17], 15);
        check("s1_table", table1, 16'h0420);
        check("s1_dis", dis1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_decoder_sweep_capture
